// File: rtl/simon_autoplayer.sv
// simon_autoplayer: records Simon playback sequences and replays them in repeat mode.
// Optional feature macro: SIMON_AUTOPLAY_FAULT_EN (adds fault_round, corrupts the last guess of that round).
module simon_autoplayer #(
   parameter int          DEPTH      = 64,
   parameter int          AW         = 6,
   parameter int          PRESS_W    = 2,
   parameter int          SETTLE     = 2,
   parameter logic [7:0]  SEED       = 8'hA5,
   parameter int          MAX_ROUNDS = 63
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    mode_leds,
   input  logic [3:0]    pattern_leds,
`ifdef SIMON_AUTOPLAY_FAULT_EN
   input  logic [AW-1:0] fault_round,
`endif
   output logic [3:0]    pattern,
   output logic          press,
   output logic          level,
   output logic [AW-1:0] rounds,
   output logic          busy,
   output logic          lost,
   output logic          win,
   output logic          err
);
   localparam int            PHW      = $clog2(PRESS_W + SETTLE + 2);
   localparam logic [PHW-1:0] PH_ONE  = PHW'(1);
   localparam logic [PHW-1:0] PH_PW   = PHW'(PRESS_W);
   localparam logic [PHW-1:0] PH_SAMP = PHW'(PRESS_W + SETTLE + 1);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   PTR_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] RND_ONE  = AW'(1);
   localparam logic [AW-1:0] RND_MAX  = AW'(MAX_ROUNDS);

   typedef enum logic [2:0] {IDLE, CHECK, INPUT, PLAYBACK, REPEAT, HALT, ERROR} state_t;

   state_t         state_q, state_d;
   logic [PHW-1:0] ph_q, ph_d;
   logic [7:0]     lfsr_q, lfsr_d;
   logic [AW:0]    wr_q, wr_d, rd_q, rd_d, len_q, len_d;
   logic [3:0]     pattern_q, pattern_d;
   logic [AW-1:0]  rounds_q, rounds_d;
   logic           press_q, press_d, busy_q, busy_d, lost_q, lost_d, win_q, win_d, err_q, err_d;
   logic           mem_we;
   logic [3:0]     guess;
   logic [3:0]     mem [DEPTH];

`ifdef SIMON_AUTOPLAY_FAULT_EN
   assign guess = mem[rd_q[AW-1:0]] ^ {3'b000, (rounds_q == fault_round) && (rd_q + PTR_ONE == len_q)};
`else
   assign guess = mem[rd_q[AW-1:0]];
`endif

   // next-state: each press state runs set-pattern / press-high / settle / sample phases counted by ph
   always_comb begin
      state_d   = state_q;
      ph_d      = '0;
      lfsr_d    = lfsr_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      len_d     = len_q;
      pattern_d = pattern_q;
      rounds_d  = rounds_q;
      lost_d    = lost_q;
      win_d     = win_q;
      mem_we    = 1'b0;
      case (state_q)
         IDLE: state_d = start ? CHECK : IDLE;
         CHECK: begin
            wr_d    = '0;
            rd_d    = '0;
            lost_d  = mode_leds == 3'b111;
            state_d = mode_leds == 3'b001 ? INPUT :
                      mode_leds == 3'b010 ? PLAYBACK :
                      mode_leds == 3'b100 ? REPEAT :
                      mode_leds == 3'b111 ? HALT : ERROR;
         end
         INPUT: begin
            ph_d = ph_q + PH_ONE;
            if (ph_q == '0) pattern_d = lfsr_q[3:0];
            if (ph_q == PH_SAMP) begin
               ph_d    = '0;
               lfsr_d  = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
               wr_d    = '0;
               state_d = mode_leds == 3'b010 ? PLAYBACK : ERROR;
            end
         end
         PLAYBACK: begin
            ph_d = ph_q + PH_ONE;
            if (ph_q == '0) begin
               if (wr_q == PTR_FULL) state_d = ERROR;
               else begin
                  mem_we = 1'b1;
                  wr_d   = wr_q + PTR_ONE;
               end
            end
            if (ph_q == PH_SAMP) begin
               ph_d    = '0;
               state_d = mode_leds == 3'b010 ? PLAYBACK : mode_leds == 3'b100 ? REPEAT : ERROR;
               if (mode_leds == 3'b100) begin
                  len_d = wr_q;
                  rd_d  = '0;
               end
            end
         end
         REPEAT: begin
            ph_d = ph_q + PH_ONE;
            if (ph_q == '0) begin
               pattern_d = guess;
               rd_d      = rd_q + PTR_ONE;
            end
            if (ph_q == PH_SAMP) begin
               ph_d = '0;
               if (mode_leds == 3'b100 && rd_q < len_q) state_d = REPEAT;
               else if (mode_leds == 3'b001 && rd_q == len_q) begin
                  rounds_d = rounds_q == RND_MAX ? rounds_q : rounds_q + RND_ONE;
                  win_d    = rounds_d == RND_MAX;
                  state_d  = win_d ? HALT : INPUT;
               end else if (mode_leds == 3'b111) begin
                  lost_d  = 1'b1;
                  state_d = HALT;
               end else state_d = ERROR;
            end
         end
         default: state_d = state_q;
      endcase
      press_d = (state_q inside {INPUT, PLAYBACK, REPEAT}) && ph_q != '0 && ph_q <= PH_PW;
      err_d   = state_d == ERROR;
      busy_d  = !(state_d inside {IDLE, HALT});
   end

   // state and registered outputs; reset drops press at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ph_q      <= '0;
         lfsr_q    <= SEED;
         wr_q      <= '0;
         rd_q      <= '0;
         len_q     <= '0;
         pattern_q <= '0;
         rounds_q  <= '0;
         press_q   <= 1'b0;
         busy_q    <= 1'b0;
         lost_q    <= 1'b0;
         win_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         lfsr_q    <= lfsr_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         len_q     <= len_d;
         pattern_q <= pattern_d;
         rounds_q  <= rounds_d;
         press_q   <= press_d;
         busy_q    <= busy_d;
         lost_q    <= lost_d;
         win_q     <= win_d;
         err_q     <= err_d;
      end
   end

   // sequence memory captures the displayed playback pattern
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_q[AW-1:0]] <= pattern_leds;
   end

   assign pattern = pattern_q;
   assign press   = press_q;
   assign level   = 1'b1;
   assign rounds  = rounds_q;
   assign busy    = busy_q;
   assign lost    = lost_q;
   assign win     = win_q;
   assign err     = err_q;
endmodule

// File: tb/tb_simon_autoplayer.sv
// tb_simon_autoplayer: plays a behavioural Simon game against the autoplayer and checks its moves.
module tb_simon_autoplayer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] mode_leds = 3'b001;
   logic [3:0] pattern_leds = 4'h0;
`ifdef SIMON_AUTOPLAY_FAULT_EN
   logic [5:0] fault_round = 6'h3F;
`endif
   logic [3:0] pattern;
   logic       press, level, busy, lost, win, err;
   logic [5:0] rounds;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] lfsr_ref;
   int         rounds_ref;
   logic [2:0] g_mode;
   logic [3:0] g_seq[$];
   int         g_idx;
   int         g_lose_at;

   always #5 clk = ~clk;

   simon_autoplayer dut (
      .clk(clk), .rst(rst), .start(start), .mode_leds(mode_leds), .pattern_leds(pattern_leds),
`ifdef SIMON_AUTOPLAY_FAULT_EN
      .fault_round(fault_round),
`endif
      .pattern(pattern), .press(press), .level(level), .rounds(rounds),
      .busy(busy), .lost(lost), .win(win), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      logic [7:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 8'b1011_1000;
      return r;
   endfunction

   task automatic game_reset();
      g_mode = 3'b001;
      g_seq.delete();
      g_idx = 0;
      g_lose_at = -1;
      lfsr_ref = 8'hA5;
      rounds_ref = 0;
      mode_leds = g_mode;
      pattern_leds = 4'($urandom_range(0, 15));
   endtask

   task automatic do_reset();
      start = 1'b0;
      rst = 1'b0;
      game_reset();
      tick(2);
      chk("rst_pattern", pattern, 4'h0);
      chk("rst_press", press, 1'b0);
      chk("rst_rounds", rounds, 6'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_lost", lost, 1'b0);
      chk("rst_win", win, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("level", level, 1'b1);
      rst = 1'b1;
      tick(1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_rise(output bit ok);
      int n = 0;
      while (press !== 1'b1 && n < 60) begin
         tick(1);
         n++;
      end
      ok = press === 1'b1;
      if (!ok) chk("press_timeout", press, 1'b1);
   endtask

   task automatic press_step(output logic [3:0] p, output bit ok);
      int w = 0;
      wait_rise(ok);
      p = pattern;
      if (!ok) return;
      while (press === 1'b1 && w < 20) begin
         chk("pattern_stable", pattern, p);
         w++;
         tick(1);
      end
      chk("press_width", w, 2);
   endtask

   task automatic game_press(output bit ok);
      logic [3:0] p;
      press_step(p, ok);
      if (!ok) return;
      case (g_mode)
         3'b001: begin
            chk("input_pattern", p, lfsr_ref[3:0]);
            chk("rounds", rounds, rounds_ref);
            chk("busy_play", busy, 1'b1);
            lfsr_ref = lfsr_step(lfsr_ref);
            g_seq.push_back(4'($urandom_range(0, 15)));
            g_mode = 3'b010;
            g_idx = 0;
            pattern_leds = g_seq[0];
         end
         3'b010: begin
            g_idx++;
            if (g_idx == g_seq.size()) begin
               g_mode = 3'b100;
               g_idx = 0;
               pattern_leds = 4'($urandom_range(0, 15));
            end else pattern_leds = g_seq[g_idx];
         end
         default: begin
            chk("repeat_guess", p, g_seq[g_idx]);
            if (p !== g_seq[g_idx] || g_idx == g_lose_at) g_mode = 3'b111;
            else begin
               g_idx++;
               if (g_idx == g_seq.size()) begin
                  g_mode = 3'b001;
                  rounds_ref++;
               end
            end
         end
      endcase
      mode_leds = g_mode;
   endtask

   task automatic play_until(input int target);
      bit ok = 1'b1;
      int guard = 0;
      while (rounds_ref < target && ok && guard < 20000) begin
         game_press(ok);
         guard++;
      end
   endtask

   initial begin
      bit ok;
      logic [3:0] p;
      int n, highs;
      tick(1);
      // normal play, then a corrupted mode during playback
      do_reset();
      pulse_start();
      tick(1);
      chk("busy_after_start", busy, 1'b1);
      n = $urandom_range(2, 5);
      play_until(n);
      game_press(ok);
      press_step(p, ok);
      mode_leds = 3'b011;
      tick(8);
      chk("err_flag", err, 1'b1);
      chk("err_busy", busy, 1'b1);
      chk("err_lost", lost, 1'b0);
      chk("err_rounds", rounds, n);
      highs = 0;
      for (int i = 0; i < 30; i++) begin
         if (press === 1'b1) highs++;
         tick(1);
      end
      chk("press_after_err", highs, 0);
      pulse_start();
      tick(3);
      chk("err_sticky", err, 1'b1);
      // reset while press is high, then a fresh game that ends in a loss
      do_reset();
      pulse_start();
      wait_rise(ok);
      rst = 1'b0;
      #1;
      chk("midrst_press", press, 1'b0);
      chk("midrst_pattern", pattern, 4'h0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rounds", rounds, 6'd0);
      tick(2);
      game_reset();
      rst = 1'b1;
      tick(1);
      pulse_start();
      n = $urandom_range(1, 4);
      play_until(n);
      g_lose_at = $urandom_range(0, n);
      for (int i = 0; i < 200 && g_mode != 3'b111 && ok; i++) game_press(ok);
      tick(10);
      chk("lost_flag", lost, 1'b1);
      chk("lost_busy", busy, 1'b0);
      chk("lost_win", win, 1'b0);
      chk("lost_err", err, 1'b0);
      chk("lost_rounds", rounds, n);
      chk("lost_press", press, 1'b0);
      // full game to the winning round count
      do_reset();
      pulse_start();
      play_until(63);
      tick(10);
      chk("win_flag", win, 1'b1);
      chk("win_rounds", rounds, 6'd63);
      chk("win_busy", busy, 1'b0);
      chk("win_lost", lost, 1'b0);
      chk("win_err", err, 1'b0);
      chk("win_press", press, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/simon_autoplayer.md
Name: simon_autoplayer

Overview:
Automated player for the Simon game. It drives the game's press clock and pattern switches, and watches the game's mode_leds and pattern_leds. It records each playback sequence into local memory, then replays that sequence in repeat mode. It counts completed rounds and flags loss or protocol errors. It is used for bring-up and regression of Simon without manual switch input.

Parameters:
DEPTH, 64, sequence memory entries (matches the Simon sequence depth)
AW, 6, memory address width, log2(DEPTH)
PRESS_W, 2, clk cycles the press output is held high
SETTLE, 2, clk cycles waited after press falls before mode_leds/pattern_leds are sampled
SEED, 8'hA5, LFSR reset value; must be nonzero
MAX_ROUNDS, 63, completed-round count that asserts win

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; leaves IDLE
mode_leds  in  3  game mode: 001 input, 010 playback, 100 repeat, 111 done
pattern_leds  in  4  game pattern display
pattern  out  4  drives game pattern switches
press  out  1  drives game pclk
level  out  1  drives game level; constant 1
rounds  out  AW  completed rounds
busy  out  1  high in every state except IDLE and HALT
lost  out  1  game reached done mode
win  out  1  rounds == MAX_ROUNDS
err  out  1  protocol error

Behaviour:
- Reset (rst low, async): pattern=0, press=0, rounds=0, busy=0, lost=0, win=0, err=0. LFSR=SEED, wr/rd pointers=0, len=0, FSM=IDLE. A reset mid-press drops press immediately.
- Press action: pattern is set in cycle 0. press rises at cycle 1 and stays high PRESS_W cycles, then falls. The FSM waits SETTLE cycles, then samples. pattern is held constant from cycle 0 until the sample.
- States: IDLE, CHECK, INPUT, PLAYBACK, REPEAT, HALT, ERROR.
- IDLE → CHECK on start.
- CHECK:
  - Decode mode_leds: 001→INPUT; 010→PLAYBACK with wr=0; 100→REPEAT with rd=0; 111→HALT with lost=1.
  - Any other value→ERROR with err=1.
- INPUT:
  - Drive pattern=lfsr[3:0], press, then advance the LFSR once.
  - LFSR is 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Then set wr=0. Expected mode is 010→PLAYBACK; otherwise ERROR.
- PLAYBACK:
  - Before each press, store mem[wr]=pattern_leds, increment wr, then press.
  - After sampling: 010 stays in PLAYBACK; 100 sets len=wr, rd=0, →REPEAT; else→ERROR.
  - Storing with wr==DEPTH-1 already written (overflow)→ERROR.
- REPEAT:
  - Drive pattern=mem[rd], press, increment rd.
  - After sampling: 100 with rd<len stays in REPEAT.
  - 001 with rd==len: increment rounds; →HALT with win=1 if rounds reaches MAX_ROUNDS; else→INPUT.
  - 111→HALT with lost=1.
  - Any other combination→ERROR.
- HALT and ERROR are sticky until reset. press=0 there; pattern holds its last value.
- start while busy is ignored.
- rounds saturates at MAX_ROUNDS.

Optional Feature:
SIMON_AUTOPLAY_FAULT_EN
- Defined: adds input fault_round[AW-1:0]. When rounds==fault_round, the final repeat guess (rd==len-1) is driven as mem[rd]^4'b0001, forcing a game loss.
- Undefined: the port is absent and guesses are always mem[rd].

Test Plan:
- Reset with Simon in input mode, pulse start → first press with pattern=4'b0101 (lfsr[3:0] of SEED 8'hA5); press high exactly 2 cycles; mode 010 sampled → PLAYBACK.
- Playback showing 4'b0101 then mode 100 → len=1, REPEAT drives 4'b0101; mode returns 001 → rounds=1, busy=1.
- Three-round game: playback of 1010, 1100, 0110 recorded in order; repeat drives the same three values; rounds increments to 3 with no err.
- mode_leds forced to 011 during a playback sample → err=1, FSM in ERROR, press stays 0 thereafter.
- Assert rst low during the press-high phase → press and all outputs go 0 within the same cycle; start after release begins a fresh game with pattern 4'b0101.
- FAULT_EN with fault_round=2 → third round's last guess has bit0 flipped; mode 111 → lost=1, rounds=2, busy=0.
